// File: rtl/agc_io_unit.sv
// Channel-mapped I/O responder for the core's IO_* port: DSKY latch, keypad FIFO,
// status/control, prescaled timer and discrete outputs, with registered one-cycle read data.
module agc_io_unit #(
   parameter int TICK_DIV = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   input  logic [2:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic        IO_write_en,
   input  logic        stall,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   output logic [14:0] dsky_out,
   output logic        dsky_strobe,
   output logic [14:0] discrete_out,
   output logic        io_irq
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      CH_DSKY     = 3'd0,
      CH_KEYIN    = 3'd1,
      CH_STATUS   = 3'd2,
      CH_TIME     = 3'd3,
      CH_DISCRETE = 3'd4
   } chan_e;

   logic [14:0]   read_data_q, read_data_d;
   logic [14:0]   dsky_q, dsky_d;
   logic          dsky_strobe_q, dsky_strobe_d;
   logic [14:0]   discrete_q, discrete_d;
   logic [14:0]   counter_q, counter_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    wr_ptr_q, wr_ptr_d;
   logic [1:0]    rd_ptr_q, rd_ptr_d;
   logic [2:0]    count_q, count_d;
   logic          key_ovf_q, key_ovf_d;
   logic          timer_ovf_q, timer_ovf_d;
   logic [4:0]    fifo_q [4];
   logic [4:0]    fifo_d [4];

   logic wr_dsky, wr_status, wr_time, wr_discrete;
   logic pop, push, drop, tick, timer_set;

   always_comb begin
      wr_dsky     = IO_write_en && (IO_write_sel == CH_DSKY);
      wr_status   = IO_write_en && (IO_write_sel == CH_STATUS);
      wr_time     = IO_write_en && (IO_write_sel == CH_TIME);
      wr_discrete = IO_write_en && (IO_write_sel == CH_DISCRETE);
      // A pop on a full FIFO frees the slot the same-cycle push needs.
      pop  = wr_status && IO_write_data[0] && (count_q != 3'd0);
      drop = key_valid && (count_q == 3'd4) && !pop;
      push = key_valid && !drop;
      tick = (presc_q == PW'(TICK_DIV - 1));
   end

   // Read mux samples pre-edge state, so a same-edge write is seen one read later.
   always_comb begin
      read_data_d = read_data_q;
      if (!stall) begin
         case (IO_read_sel)
            CH_DSKY:     read_data_d = dsky_q;
            CH_KEYIN:    read_data_d = (count_q != 3'd0) ? {1'b1, 9'b0, fifo_q[rd_ptr_q]} : 15'h0;
            CH_STATUS:   read_data_d = {10'b0, timer_ovf_q, key_ovf_q, count_q};
            CH_TIME:     read_data_d = counter_q;
            CH_DISCRETE: read_data_d = discrete_q;
            default:     read_data_d = 15'h0;
         endcase
      end
   end

   // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
   always_comb begin
      dsky_d        = wr_dsky ? IO_write_data : dsky_q;
      dsky_strobe_d = wr_dsky;
      discrete_d    = wr_discrete ? IO_write_data : discrete_q;

      fifo_d = fifo_q;
      if (push) fifo_d[wr_ptr_q] = key_code;
      wr_ptr_d = wr_ptr_q + {1'b0, push};
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      count_d  = count_q + {2'b0, push} - {2'b0, pop};

      // Sticky sets win over same-cycle clears.
      key_ovf_d = drop | (key_ovf_q & ~(wr_status & IO_write_data[3]));

      counter_d = counter_q;
      presc_d   = presc_q;
      timer_set = 1'b0;
      if (wr_time) begin
         counter_d = IO_write_data;
         presc_d   = '0;
      end else if (tick) begin
         presc_d   = '0;
         counter_d = counter_q + 15'd1;
         timer_set = (counter_q == 15'h7FFF);
      end else begin
         presc_d = presc_q + PW'(1);
      end
      timer_ovf_d = timer_set | (timer_ovf_q & ~(wr_status & IO_write_data[4]));
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_data_q   <= '0;
         dsky_q        <= '0;
         dsky_strobe_q <= 1'b0;
         discrete_q    <= '0;
         counter_q     <= '0;
         presc_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         key_ovf_q     <= 1'b0;
         timer_ovf_q   <= 1'b0;
      end else begin
         read_data_q   <= read_data_d;
         dsky_q        <= dsky_d;
         dsky_strobe_q <= dsky_strobe_d;
         discrete_q    <= discrete_d;
         counter_q     <= counter_d;
         presc_q       <= presc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         key_ovf_q     <= key_ovf_d;
         timer_ovf_q   <= timer_ovf_d;
      end
   end

   // NOTE: FIFO storage has no reset; count_q == 0 already hides stale entries.
   always_ff @(posedge clock) begin
      fifo_q <= fifo_d;
   end

   assign IO_read_data = read_data_q;
   assign dsky_out     = dsky_q;
   assign dsky_strobe  = dsky_strobe_q;
   assign discrete_out = discrete_q;
   assign io_irq       = (count_q != 3'd0) | timer_ovf_q;

endmodule

// File: tb/tb_agc_io_unit.sv
// Bench for agc_io_unit: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_agc_io_unit;

   localparam int TICK_DIV = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic [2:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic        IO_write_en;
   logic        stall;
   logic        key_valid;
   logic [4:0]  key_code;
   logic [14:0] dsky_out;
   logic        dsky_strobe;
   logic [14:0] discrete_out;
   logic        io_irq;

   int n_cmp  = 0;
   int n_fail = 0;

   agc_io_unit #(.TICK_DIV(TICK_DIV)) dut (
      .clock         (clock),
      .reset         (reset),
      .IO_read_sel   (IO_read_sel),
      .IO_read_data  (IO_read_data),
      .IO_write_sel  (IO_write_sel),
      .IO_write_data (IO_write_data),
      .IO_write_en   (IO_write_en),
      .stall         (stall),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .dsky_out      (dsky_out),
      .dsky_strobe   (dsky_strobe),
      .discrete_out  (discrete_out),
      .io_irq        (io_irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain registers, a keycode queue and integer timer.
   logic [14:0] m_rd, m_dsky, m_disc, m_cnt;
   logic        m_strobe, m_kovf, m_tovf;
   logic        m_valid = 1'b0;
   logic [4:0]  m_q [$];
   int          m_pre;

   function automatic logic [14:0] m_chan(input logic [2:0] sel);
      case (sel)
         3'd0:    return m_dsky;
         3'd1:    return (m_q.size() > 0) ? {1'b1, 9'b0, m_q[0]} : 15'h0;
         3'd2:    return {10'b0, m_tovf, m_kovf, 3'(m_q.size())};
         3'd3:    return m_cnt;
         3'd4:    return m_disc;
         default: return 15'h0;
      endcase
   endfunction

   always @(posedge clock) begin : model
      bit w0, w2, w3, w4, pop, drop, tick;
      logic [14:0] wd;
      if (reset) begin
         m_rd = '0; m_dsky = '0; m_disc = '0; m_cnt = '0; m_pre = 0;
         m_strobe = 1'b0; m_kovf = 1'b0; m_tovf = 1'b0;
         m_q.delete();
         m_valid = 1'b1;
      end else begin
         wd   = IO_write_data;
         w0   = IO_write_en && IO_write_sel == 3'd0;
         w2   = IO_write_en && IO_write_sel == 3'd2;
         w3   = IO_write_en && IO_write_sel == 3'd3;
         w4   = IO_write_en && IO_write_sel == 3'd4;
         tick = (m_pre == TICK_DIV - 1);
         if (!stall) m_rd = m_chan(IO_read_sel);
         m_strobe = w0;
         if (w0) m_dsky = wd;
         if (w4) m_disc = wd;
         pop  = w2 && wd[0] && m_q.size() > 0;
         drop = key_valid && m_q.size() == 4 && !pop;
         if (pop) void'(m_q.pop_front());
         if (key_valid && !drop) m_q.push_back(key_code);
         if (w2 && wd[3]) m_kovf = 1'b0;
         if (drop) m_kovf = 1'b1;
         if (w2 && wd[4]) m_tovf = 1'b0;
         if (w3) begin
            m_cnt = wd;
            m_pre = 0;
         end else if (tick) begin
            m_pre = 0;
            if (m_cnt == 15'h7FFF) m_tovf = 1'b1;
            m_cnt = m_cnt + 15'd1;
         end else begin
            m_pre++;
         end
      end
   end

   always @(negedge clock) begin
      if (m_valid) begin
         check("model_read_data", IO_read_data, m_rd);
         check("model_dsky_out", dsky_out, m_dsky);
         check("model_dsky_strobe", {14'b0, dsky_strobe}, {14'b0, m_strobe});
         check("model_discrete_out", discrete_out, m_disc);
         check("model_io_irq", {14'b0, io_irq}, {14'b0, (m_q.size() != 0) || m_tovf});
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [14:0] d);
      IO_write_en = 1'b1; IO_write_sel = sel; IO_write_data = d;
      cyc();
      IO_write_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] sel, input string name, input logic [14:0] exp);
      IO_read_sel = sel;
      cyc();
      check(name, IO_read_data, exp);
   endtask

   task automatic push(input logic [4:0] k);
      key_valid = 1'b1; key_code = k;
      cyc();
      key_valid = 1'b0;
   endtask

   initial begin
      logic [14:0] pop_exp [4];
      pop_exp = '{15'h4006, 15'h4007, 15'h4008, 15'h0000};
      reset = 1'b1; IO_read_sel = '0; IO_write_sel = '0; IO_write_data = '0;
      IO_write_en = 1'b0; stall = 1'b0; key_valid = 1'b0; key_code = '0;
      cyc(2);
      reset = 1'b0;

      // Reset state of every channel
      for (int ch = 0; ch < 8; ch++) rd(3'(ch), $sformatf("reset_ch%0d", ch), 15'h0);
      check("reset_irq", {14'b0, io_irq}, 15'h0);
      check("reset_strobe", {14'b0, dsky_strobe}, 15'h0);

      // DSKY write, strobe pulse, stall hold
      wr(3'd0, 15'h1234);
      check("dsky_out", dsky_out, 15'h1234);
      check("strobe_high", {14'b0, dsky_strobe}, 15'h1);
      cyc();
      check("strobe_low", {14'b0, dsky_strobe}, 15'h0);
      rd(3'd0, "dsky_read", 15'h1234);
      IO_read_sel = 3'd1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_hold", IO_read_data, 15'h1234);
      end
      stall = 1'b0;

      // Overfilling the keypad FIFO, then draining it
      for (int k = 5; k <= 9; k++) push(5'(k));
      rd(3'd2, "ovf_status", 15'h000C);
      rd(3'd1, "fifo_head", 15'h4005);
      check("irq_fifo", {14'b0, io_irq}, 15'h1);
      for (int i = 0; i < 4; i++) begin
         wr(3'd2, 15'h0001);
         rd(3'd1, $sformatf("pop_head%0d", i), pop_exp[i]);
      end
      check("irq_drained", {14'b0, io_irq}, 15'h0);
      wr(3'd2, 15'h0008);
      rd(3'd2, "kovf_cleared", 15'h0000);

      // Full FIFO with simultaneous push and pop
      for (int k = 1; k <= 4; k++) push(5'(k));
      key_valid = 1'b1; key_code = 5'd10;
      wr(3'd2, 15'h0001);
      key_valid = 1'b0;
      rd(3'd2, "pushpop_status", 15'h0004);
      rd(3'd1, "pushpop_head", 15'h4002);
      for (int i = 0; i < 4; i++) wr(3'd2, 15'h0001);
      rd(3'd2, "pushpop_drained", 15'h0000);

      // Timer wrap, overflow flag, and load in a tick cycle
      wr(3'd3, 15'h7FFE);
      cyc(4);
      rd(3'd3, "timer_7fff", 15'h7FFF);
      cyc(3);
      rd(3'd3, "timer_wrap", 15'h0000);
      rd(3'd2, "tovf_status", 15'h0010);
      check("irq_timer", {14'b0, io_irq}, 15'h1);
      wr(3'd2, 15'h0010);
      rd(3'd2, "tovf_cleared", 15'h0000);
      check("irq_timer_clr", {14'b0, io_irq}, 15'h0);
      wr(3'd3, 15'h00FF);
      cyc(3);
      wr(3'd3, 15'h0100);
      rd(3'd3, "tick_write_wins", 15'h0100);
      cyc(3);
      rd(3'd3, "presc_zeroed", 15'h0101);

      // Overflowing push beats a same-cycle key_ovf clear
      wr(3'd0, 15'h7777);
      for (int k = 1; k <= 4; k++) push(5'(k));
      key_valid = 1'b1; key_code = 5'h1F;
      wr(3'd2, 15'h0008);
      key_valid = 1'b0;
      rd(3'd2, "kovf_set_wins", 15'h000C);

      // Reset in the middle of filling, with a push and a write pending
      reset = 1'b1; cyc(); reset = 1'b0;
      push(5'd1); push(5'd2);
      reset = 1'b1; key_valid = 1'b1; key_code = 5'd3;
      IO_write_en = 1'b1; IO_write_sel = 3'd0; IO_write_data = 15'h5555;
      cyc();
      reset = 1'b0; key_valid = 1'b0; IO_write_en = 1'b0;
      check("midreset_irq", {14'b0, io_irq}, 15'h0);
      check("midreset_dsky", dsky_out, 15'h0);
      rd(3'd2, "midreset_status", 15'h0000);

      // Discrete register, read-before-write, ignored channels
      wr(3'd4, 15'h5A5A);
      check("discrete_out", discrete_out, 15'h5A5A);
      rd(3'd4, "discrete_read", 15'h5A5A);
      IO_read_sel = 3'd4;
      wr(3'd4, 15'h0F0F);
      check("read_before_write", IO_read_data, 15'h5A5A);
      rd(3'd4, "discrete_new", 15'h0F0F);
      wr(3'd5, 15'h1111);
      wr(3'd1, 15'h2222);
      rd(3'd5, "ch5_zero", 15'h0000);
      rd(3'd1, "ch1_ro", 15'h0000);
      rd(3'd7, "ch7_zero", 15'h0000);

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/agc_io_unit.md
# agc_io_unit

Channel-mapped I/O responder on the core's `IO_*` port, the device side of the core's 3-bit select read/write protocol. It sits beside the ROM and RAM in the top-level bench and system. It provides:
- a DSKY display output latch;
- a 4-deep keypad input FIFO;
- a status/control channel;
- a prescaled 15-bit timer;
- a discrete output register.

Read data is registered with one-cycle latency and honours `stall`, so the core sees the same timing as the RAM/ROM read ports.

## Interface
- `TICK_DIV`, 1024: clock cycles per timer increment; legal range ≥ 2.

Ports (reset is synchronous and active-high):
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `IO_read_sel` in 3: channel to read.
- `IO_read_data` out 15: registered read data.
- `IO_write_sel` in 3: channel to write.
- `IO_write_data` in 15: write data.
- `IO_write_en` in 1: write strobe, one write per asserted cycle.
- `stall` in 1: freezes the read pipeline.
- `key_valid` in 1: keypad push strobe, one push per asserted cycle.
- `key_code` in 5: keycode presented with `key_valid`.
- `dsky_out` out 15: channel-0 latch.
- `dsky_strobe` out 1: one-cycle pulse after each channel-0 write.
- `discrete_out` out 15: channel-4 register.
- `io_irq` out 1: `(fifo_count != 0) | timer_ovf`, decoded from registers.

## Operation
Channel map:
- **Ch 0, DSKY (R/W):** write loads `dsky_out`; read returns it.
- **Ch 1, KEYIN (RO):**
  - FIFO non-empty: `{1'b1, 9'b0, head_keycode}`.
  - FIFO empty: `15'h0`.
  - Writes ignored.
- **Ch 2, STATUS/CTRL:**
  - Read returns `{10'b0, timer_ovf, key_ovf, fifo_count[2:0]}`, `fifo_count` 0..4.
  - Write bit0 = 1 pops the FIFO; a pop when empty does nothing.
  - Write bit3 = 1 clears `key_ovf`.
  - Write bit4 = 1 clears `timer_ovf`.
  - All other write bits are ignored.
- **Ch 3, TIME (R/W):**
  - Write loads the counter and zeroes the prescaler.
  - Read returns the counter value.
- **Ch 4, DISCRETE (R/W):** write loads `discrete_out`; read returns it.
- **Ch 5–7:** read `15'h0`; writes ignored.

Reads have no side effects. The FIFO head is consumed only by a ch-2 pop.

Keypad FIFO (4 entries, circular, 2-bit read/write pointers):
- Push occurs when `key_valid`.
- Push while full with no same-cycle pop: the code is dropped and `key_ovf` is set (sticky).
- Push and pop in the same cycle:
  - When full, both succeed; count stays 4, no overflow.
  - When empty, the pop is a no-op and the push succeeds; count becomes 1.
- Pointers wrap 3 → 0.

Timer:
- The prescaler counts 0..`TICK_DIV`-1. The cycle where it equals `TICK_DIV`-1 is a tick; the prescaler then returns to 0.
- On a tick the counter increments. From `15'h7FFF` it wraps to `15'h0000` and sets `timer_ovf`.
- A ch-3 write in a tick cycle wins: the counter is loaded and no increment or overflow occurs.

Set/clear priority: when a sticky set and a ch-2 clear hit the same flag in the same cycle, the set wins.

`dsky_strobe` is 1 in the cycle after a ch-0 write, else 0.

## Timing
- **Reset values:**
  - `IO_read_data`, `dsky_out`, `discrete_out`, counter, prescaler: 0.
  - `dsky_strobe` = 0.
  - FIFO empty, both flags 0, so `io_irq` = 0.
  - Reset overrides writes, pushes and ticks in the same cycle.
- **Read, stall = 0:** at edge N, `IO_read_data` ← contents of channel `IO_read_sel`, sampled as the pre-edge state. The value is therefore valid in cycle N+1.
- **Read, stall = 1:** `IO_read_data` holds its value.
- **Same-edge read and write to one channel:** the read returns the old value (read-before-write).
- **Write:** takes effect at the edge where `IO_write_en` = 1 and is visible to a read sampled at the next edge. Writes are not gated by `stall`.
- **Pushes:** one push per cycle; a pushed code is readable on ch 1 from the next edge.
- **`io_irq`:** updates the cycle after the state change that drives it.

## Test plan
- Reset, then read ch 0..7 → all `15'h0`; `io_irq` = 0, `dsky_strobe` = 0.
- Write ch0 = `15'h1234`, read ch0 → `dsky_out` = `15'h1234`, `dsky_strobe` is high for exactly 1 cycle, read data = `15'h1234` one cycle after the select. With `stall` held for 3 cycles, `IO_read_data` stays unchanged.
- Push keycodes 5, 6, 7, 8, 9 with no pops:
  - ch2 → count 4, `key_ovf` = 1.
  - ch1 → `15'h4005`.
  - Pop four times → ch1 shows `15'h4006`, `15'h4007`, `15'h4008`, then `15'h0`.
  - `io_irq` drops after the last pop.
- FIFO full, with a push and a pop in the same cycle → count stays 4, `key_ovf` unchanged, head advances.
- `TICK_DIV` = 4, write ch3 = `15'h7FFE`:
  - Counter reads `15'h7FFF` after 4 cycles, `15'h0000` after 8, and `timer_ovf` = 1.
  - Writing ch2 bit4 clears `timer_ovf`.
  - A ch3 write of `15'h0100` in a tick cycle → counter reads `15'h0100`, not `15'h0101`.
- Write ch2 bit3 in the same cycle as an overflowing push → `key_ovf` remains 1. Assert `reset` mid-FIFO-fill → next cycle count 0, all flags 0.
